uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rr_arbiter.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit arbiter.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } uart_state_e;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin winner search starting at ptr and wrapping modulo NUM_REQ.
module uart_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       valid
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    int unsigned          sum;
    logic [ID_W-1:0]      sel;

    // Scan from the farthest offset down so the nearest requester to ptr wins last-write.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        sum    = 0;
        sel    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = 32'(ptr) + 32'(k);
            sel = ID_W'(sum % NUM_REQ);
            if (req[sel]) begin
                winner = sel;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding NUM_REQ byte streams into one UART transmitter.
// Defining UART_TX_ARB_TIMEOUT_EN adds a FETCH stall abort after TIMEOUT_CYCLES idle cycles.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           tx_enable,
    output logic [UART_DATA_W-1:0]         data_tx,
    output logic                           data_tx_wr,
    input  logic                           data_tx_ack,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy,
    output logic                           timeout_pulse
);
    localparam int unsigned ID_W     = $clog2(NUM_REQ);
    localparam logic [1:0]  ST_IDLE  = 2'(IDLE);
    localparam logic [1:0]  ST_FETCH = 2'(FETCH);
    localparam logic [1:0]  ST_SEND  = 2'(SEND);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    logic [1:0]             state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d, ptr_next;
    logic [ID_W-1:0]        grant_d, win_id;
    logic                   win_valid;
    logic [UART_DATA_W-1:0] data_d;
    logic                   wr_d, last_q, last_d;
    logic                   grant_valid, stall_abort;
    logic [UART_DATA_W-1:0] req_bytes [NUM_REQ];

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req    (req_valid),
        .ptr    (ptr_q),
        .winner (win_id),
        .valid  (win_valid)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data[i*UART_DATA_W +: UART_DATA_W];
        end
    end

    assign grant_valid = req_valid[grant_id];
    assign ptr_next    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    assign busy        = (state_q != ST_IDLE);

    always_comb begin
        req_ready = '0;
        if (state_q == ST_FETCH) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Next-state and datapath updates; the grant is held for the whole packet.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_id;
        data_d  = data_tx;
        wr_d    = data_tx_wr;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_enable && win_valid) begin
                    grant_d = win_id;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (grant_valid) begin
                    data_d  = req_bytes[grant_id];
                    last_d  = req_last[grant_id];
                    wr_d    = 1'b1;
                    state_d = ST_SEND;
                end else if (stall_abort) begin
                    ptr_d   = ptr_next;
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (data_tx_ack) begin
                    wr_d = 1'b0;
                    if (last_q) begin
                        ptr_d   = ptr_next;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            grant_id   <= '0;
            data_tx    <= '0;
            data_tx_wr <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id   <= grant_d;
            data_tx    <= data_d;
            data_tx_wr <= wr_d;
            last_q     <= last_d;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES);

    logic [TCNT_W-1:0] tcnt_q;

    assign stall_abort = (state_q == ST_FETCH) && !grant_valid &&
                         (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1));

    // Counts consecutive starved FETCH cycles; any accept or state change restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q        <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= stall_abort;
            if (state_q == ST_FETCH && !grant_valid && !stall_abort) begin
                tcnt_q <= tcnt_q + TCNT_W'(1);
            end else begin
                tcnt_q <= '0;
            end
        end
    end
`else
    assign stall_abort   = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle table plus hand-written multi-cycle sequences.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        tx_enable = 1'b0;
    logic [7:0]  data_tx;
    logic        data_tx_wr;
    logic        data_tx_ack = 1'b0;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_pulse;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_enable     (tx_enable),
        .data_tx       (data_tx),
        .data_tx_wr    (data_tx_wr),
        .data_tx_ack   (data_tx_ack),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        en;
        logic        ack;
        logic [3:0]  e_ready;
        logic [7:0]  e_data;
        logic        e_wr;
        logic [1:0]  e_gid;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    logic [8:0] pk [4][4];
    int         pk_n [4];
    int         pk_st [4];
    logic [9:0] exp_log[$];
    logic [9:0] got_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic [3:0] v, input logic [31:0] d,
                                input logic [3:0] l, input logic en, input logic ack,
                                input logic [3:0] e_ready, input logic [7:0] e_data,
                                input logic e_wr, input logic [1:0] e_gid, input logic e_busy);
        vec_t x;
        x.rst = r; x.valid = v; x.data = d; x.last = l; x.en = en; x.ack = ack;
        x.e_ready = e_ready; x.e_data = e_data; x.e_wr = e_wr; x.e_gid = e_gid; x.e_busy = e_busy;
        vecs.push_back(x);
    endfunction

    // Requesters present queued bytes; the UART acks on the second cycle of each write.
    task automatic run_traffic(input string name, input int max_cyc);
        int         pi [4];
        int         j;
        logic [3:0] hs;
        int         wr_cnt;
        logic       v;
        hs     = '0;
        wr_cnt = 0;
        got_log.delete();
        for (int i = 0; i < 4; i++) pi[i] = 0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (hs[i]) pi[i]++;
            if (got_log.size() >= exp_log.size()) break;
            for (int i = 0; i < 4; i++) begin
                j = (pi[i] < 4) ? pi[i] : 3;
                v = (cyc >= pk_st[i]) && (pi[i] < pk_n[i]);
                req_valid[i]          = v;
                req_data[8*i +: 8]    = v ? pk[i][j][7:0] : 8'h00;
                req_last[i]           = v & pk[i][j][8];
            end
            wr_cnt      = data_tx_wr ? wr_cnt + 1 : 0;
            data_tx_ack = (wr_cnt == 2);
            if (wr_cnt == 2) got_log.push_back({grant_id, data_tx});
            hs = req_ready & req_valid;
        end
        data_tx_ack = 1'b0;
        req_valid   = '0;
        req_last    = '0;
        req_data    = '0;
        check({name, "_count"}, 32'(got_log.size()), 32'(exp_log.size()));
        for (int k = 0; k < exp_log.size(); k++) begin
            check($sformatf("%s_byte%0d", name, k),
                  (k < got_log.size()) ? 32'(got_log[k]) : 32'h3FF, 32'(exp_log[k]));
        end
    endtask

    task automatic wait_wr(input string name);
        for (int k = 0; k < 20 && data_tx_wr !== 1'b1; k++) @(negedge clk);
        check(name, 32'(data_tx_wr), 32'd1);
    endtask

    initial begin
        logic ok;

        // 3-byte packet on req0, ack on the second write cycle.
        add(0, 4'b0001, 32'h41, 4'b0000, 1, 0, 4'b0000, 8'h00, 0, 0, 0);
        add(0, 4'b0001, 32'h41, 4'b0000, 1, 0, 4'b0001, 8'h00, 0, 0, 1);
        add(0, 4'b0001, 32'h42, 4'b0000, 1, 0, 4'b0000, 8'h41, 1, 0, 1);
        add(0, 4'b0001, 32'h42, 4'b0000, 1, 1, 4'b0000, 8'h41, 1, 0, 1);
        add(0, 4'b0001, 32'h42, 4'b0000, 1, 0, 4'b0001, 8'h41, 0, 0, 1);
        add(0, 4'b0001, 32'h43, 4'b0001, 1, 0, 4'b0000, 8'h42, 1, 0, 1);
        add(0, 4'b0001, 32'h43, 4'b0001, 1, 1, 4'b0000, 8'h42, 1, 0, 1);
        add(0, 4'b0001, 32'h43, 4'b0001, 1, 0, 4'b0001, 8'h42, 0, 0, 1);
        add(0, 4'b0000, 32'h00, 4'b0000, 1, 0, 4'b0000, 8'h43, 1, 0, 1);
        add(0, 4'b0000, 32'h00, 4'b0000, 1, 1, 4'b0000, 8'h43, 1, 0, 1);
        add(0, 4'b0000, 32'h00, 4'b0000, 1, 0, 4'b0000, 8'h43, 0, 0, 0);
        // Reset to ptr=0, then req1 and req2 together; then req0 and req3 with ptr=3.
        add(1, 4'b0000, 32'h00, 4'b0000, 0, 0, 4'b0000, 8'h43, 0, 0, 0);
        add(0, 4'b0110, 32'h0022_1100, 4'b0110, 1, 0, 4'b0000, 8'h00, 0, 0, 0);
        add(0, 4'b0110, 32'h0022_1100, 4'b0110, 1, 0, 4'b0010, 8'h00, 0, 1, 1);
        add(0, 4'b0100, 32'h0022_1100, 4'b0110, 1, 0, 4'b0000, 8'h11, 1, 1, 1);
        add(0, 4'b0100, 32'h0022_1100, 4'b0110, 1, 1, 4'b0000, 8'h11, 1, 1, 1);
        add(0, 4'b0100, 32'h0022_1100, 4'b0110, 1, 0, 4'b0000, 8'h11, 0, 1, 0);
        add(0, 4'b0100, 32'h0022_1100, 4'b0110, 1, 0, 4'b0100, 8'h11, 0, 2, 1);
        add(0, 4'b0000, 32'h00, 4'b0000, 1, 1, 4'b0000, 8'h22, 1, 2, 1);
        add(0, 4'b1001, 32'hD300_00A0, 4'b1001, 1, 0, 4'b0000, 8'h22, 0, 2, 0);
        add(0, 4'b1001, 32'hD300_00A0, 4'b1001, 1, 0, 4'b1000, 8'h22, 0, 3, 1);
        add(0, 4'b0001, 32'hD300_00A0, 4'b1001, 1, 1, 4'b0000, 8'hD3, 1, 3, 1);
        // tx_enable low blocks grants; stray ack in IDLE is ignored.
        add(0, 4'b0001, 32'hD300_00A0, 4'b1001, 0, 0, 4'b0000, 8'hD3, 0, 3, 0);
        add(0, 4'b0001, 32'hD300_00A0, 4'b1001, 0, 1, 4'b0000, 8'hD3, 0, 3, 0);
        add(0, 4'b0001, 32'hD300_00A0, 4'b1001, 1, 0, 4'b0000, 8'hD3, 0, 3, 0);
        add(0, 4'b0001, 32'hD300_00A0, 4'b1001, 1, 0, 4'b0001, 8'hD3, 0, 0, 1);
        add(0, 4'b0000, 32'h00, 4'b0000, 1, 1, 4'b0000, 8'hA0, 1, 0, 1);
        // req2 packet with ptr=1, reset mid-SEND; pending req0/req3 must restart from ptr=0.
        add(0, 4'b0100, 32'h005A_0000, 4'b0100, 1, 0, 4'b0000, 8'hA0, 0, 0, 0);
        add(0, 4'b0100, 32'h005A_0000, 4'b0100, 1, 0, 4'b0100, 8'hA0, 0, 2, 1);
        add(1, 4'b1001, 32'hD300_00A0, 4'b1001, 1, 0, 4'b0000, 8'h5A, 1, 2, 1);
        add(0, 4'b1001, 32'hD300_00A0, 4'b1001, 1, 0, 4'b0000, 8'h00, 0, 0, 0);
        add(0, 4'b1001, 32'hD300_00A0, 4'b1001, 1, 0, 4'b0001, 8'h00, 0, 0, 1);
        add(0, 4'b0000, 32'h00, 4'b0000, 1, 1, 4'b0000, 8'hA0, 1, 0, 1);
        add(0, 4'b0000, 32'h00, 4'b0000, 1, 0, 4'b0000, 8'hA0, 0, 0, 0);

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_wr", 32'(data_tx_wr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);
        check("rst_data", 32'(data_tx), 32'd0);
        check("rst_pulse", 32'(timeout_pulse), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
            check($sformatf("v%0d_data", i), 32'(data_tx), 32'(vecs[i].e_data));
            check($sformatf("v%0d_wr", i), 32'(data_tx_wr), 32'(vecs[i].e_wr));
            check($sformatf("v%0d_gid", i), 32'(grant_id), 32'(vecs[i].e_gid));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("v%0d_pulse", i), 32'(timeout_pulse), 32'd0);
            rst         = vecs[i].rst;
            req_valid   = vecs[i].valid;
            req_data    = vecs[i].data;
            req_last    = vecs[i].last;
            tx_enable   = vecs[i].en;
            data_tx_ack = vecs[i].ack;
        end

        // Packet lock: req3 arrives while req0 is mid-packet and must wait.
        for (int i = 0; i < 4; i++) begin
            pk_n[i]  = 0;
            pk_st[i] = 0;
            for (int k = 0; k < 4; k++) pk[i][k] = '0;
        end
        pk[0][0] = {1'b0, 8'h61};
        pk[0][1] = {1'b1, 8'h62};
        pk_n[0]  = 2;
        pk[3][0] = {1'b1, 8'h7E};
        pk_n[3]  = 1;
        pk_st[3] = 2;
        exp_log.delete();
        exp_log.push_back({2'd0, 8'h61});
        exp_log.push_back({2'd0, 8'h62});
        exp_log.push_back({2'd3, 8'h7E});
        tx_enable = 1'b1;
        run_traffic("lock", 60);

        // Long ack stall: write and byte must hold for 50 cycles.
        @(negedge clk);
        req_valid = 4'b0010;
        req_data  = 32'h0000_9900;
        req_last  = 4'b0010;
        wait_wr("hold_wr_rise");
        req_valid = '0;
        req_last  = '0;
        ok = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (data_tx_wr !== 1'b1 || data_tx !== 8'h99) ok = 1'b0;
            @(negedge clk);
        end
        check("hold_stable", 32'(ok), 32'd1);
        data_tx_ack = 1'b1;
        @(negedge clk);
        data_tx_ack = 1'b0;
        check("hold_wr_fall", 32'(data_tx_wr), 32'd0);
        check("hold_idle", 32'(busy), 32'd0);
        check("hold_data", 32'(data_tx), 32'h99);

        // req2 stalls mid-packet while req3 waits.
        @(negedge clk);
        req_valid = 4'b0100;
        req_data  = 32'h0033_0000;
        req_last  = 4'b0000;
        wait_wr("stall_wr");
        req_valid = 4'b1000;
        req_data  = 32'h7F00_0000;
        req_last  = 4'b1000;
        @(negedge clk);
        data_tx_ack = 1'b1;
        @(negedge clk);
        data_tx_ack = 1'b0;
        ok = 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) @(negedge clk);
            if (req_ready !== 4'b0100 || busy !== 1'b1 || timeout_pulse !== 1'b0 || grant_id !== 2'd2)
                ok = 1'b0;
        end
        check("stall_hold", 32'(ok), 32'd1);
        @(negedge clk);
        check("to_pulse", 32'(timeout_pulse), 32'd1);
        check("to_idle", 32'(busy), 32'd0);
        check("to_ready", 32'(req_ready), 32'd0);
        req_valid = 4'b1100;
        req_data  = 32'h7F35_0000;
        req_last  = 4'b1100;
        @(negedge clk);
        check("to_pulse_once", 32'(timeout_pulse), 32'd0);
        check("to_next_gid", 32'(grant_id), 32'd3);
        check("to_next_ready", 32'(req_ready), 32'(4'b1000));
`else
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (req_ready !== 4'b0100 || busy !== 1'b1 || timeout_pulse !== 1'b0 || grant_id !== 2'd2)
                ok = 1'b0;
        end
        check("stall_hold", 32'(ok), 32'd1);
        req_valid = 4'b1100;
        req_data  = 32'h7F34_0000;
        req_last  = 4'b1100;
        @(negedge clk);
        check("stall_resume_wr", 32'(data_tx_wr), 32'd1);
        check("stall_resume_data", 32'(data_tx), 32'h34);
        check("stall_resume_gid", 32'(grant_id), 32'd2);
        req_valid = 4'b1000;
        @(negedge clk);
        data_tx_ack = 1'b1;
        @(negedge clk);
        data_tx_ack = 1'b0;
        req_valid   = 4'b1100;
        check("stall_done_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check("stall_next_gid", 32'(grant_id), 32'd3);
        check("stall_next_ready", 32'(req_ready), 32'(4'b1000));
        check("stall_no_pulse", 32'(timeout_pulse), 32'd0);
`endif
        @(negedge clk);
        req_valid = '0;
        req_last  = '0;
        @(negedge clk);
        data_tx_ack = 1'b1;
        @(negedge clk);
        data_tx_ack = 1'b0;
        check("tail_idle", 32'(busy), 32'd0);
        check("tail_data", 32'(data_tx), 32'h7F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
